wb_queue: RTL and testbench

Write-back queue that sits directly upstream of the 32x32 register file and owns its single synchronous write port. It accepts up to two write-back requests per cycle, one from the ALU path and one from the load path, buffers them in an in-order FIFO, and retires one entry per cycle onto the register file's WriteRegister/WriteData/RegWrite inputs. Two lookup ports let the register-read stage forward values that are still queued and not yet in the register file.

---
 rtl/wb_queue.sv | 120 ++++++++++++
 tb/tb_wb_queue.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Write-back queue owning the regfile write port: dual enqueue, single
// in-order retire, and two forwarding lookups over still-queued entries.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             LoadValid,
    input  logic [4:0]       LoadReg,
    input  logic [WIDTH-1:0] LoadData,
    input  logic             AluValid,
    input  logic [4:0]       AluReg,
    input  logic [WIDTH-1:0] AluData,
    output logic             Stall,
    output logic             Overflow,
    output logic [4:0]       WriteRegister,
    output logic [WIDTH-1:0] WriteData,
    output logic             RegWrite,
    input  logic [4:0]       QueryReg1,
    input  logic [4:0]       QueryReg2,
    output logic             Hit1,
    output logic             Hit2,
    output logic [WIDTH-1:0] HitData1,
    output logic [WIDTH-1:0] HitData2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = PW + 1;

    logic [4:0]       regMem  [DEPTH];
    logic [WIDTH-1:0] dataMem [DEPTH];

    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [CW-1:0] count;

    logic          pop;
    logic          loadAcc;
    logic          aluAcc;
    logic [PW-1:0] aluSlot;
    logic [PW-1:0] wptrNext;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign Stall   = (count >= CW'(DEPTH - 1));
    assign pop     = (count != '0);
    assign loadAcc = !Stall && LoadValid && (LoadReg != 5'd0);
    assign aluAcc  = !Stall && AluValid && (AluReg != 5'd0);

    // Load is the older of a same-cycle pair, so ALU takes the slot after it.
    assign aluSlot  = loadAcc ? nextPtr(wptr) : wptr;
    assign wptrNext = aluAcc  ? nextPtr(aluSlot) : aluSlot;

    // Gated by ResetN so the regfile never captures a write at a reset edge.
    assign RegWrite      = ResetN && pop;
    assign WriteRegister = pop ? regMem[rptr]  : 5'd0;
    assign WriteData     = pop ? dataMem[rptr] : '0;

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            count    <= '0;
            rptr     <= '0;
            wptr     <= '0;
            Overflow <= 1'b0;
        end else begin
            if (loadAcc) begin
                regMem[wptr]  <= LoadReg;
                dataMem[wptr] <= LoadData;
            end
            if (aluAcc) begin
                regMem[aluSlot]  <= AluReg;
                dataMem[aluSlot] <= AluData;
            end
            if (pop) begin
                rptr <= nextPtr(rptr);
            end
            wptr  <= wptrNext;
            count <= count + CW'(loadAcc) + CW'(aluAcc) - CW'(pop);
            if (Stall && (LoadValid || AluValid)) begin
                Overflow <= 1'b1;
            end
        end
    end

    logic [IW-1:0] sum;
    logic [PW-1:0] idx;
    logic          live;

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        Hit1     = 1'b0;
        Hit2     = 1'b0;
        HitData1 = '0;
        HitData2 = '0;
        sum      = '0;
        idx      = '0;
        live     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sum = IW'(rptr) + IW'(i);
            if (sum >= IW'(DEPTH)) begin
                sum = sum - IW'(DEPTH);
            end
            idx  = sum[PW-1:0];
            live = (CW'(i) < count);
            if (live && QueryReg1 != 5'd0 && regMem[idx] == QueryReg1) begin
                Hit1     = 1'b1;
                HitData1 = dataMem[idx];
            end
            if (live && QueryReg2 != 5'd0 && regMem[idx] == QueryReg2) begin
                Hit2     = 1'b1;
                HitData2 = dataMem[idx];
            end
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: inputs change 1ns after the rising edge and
// outputs are checked in that same window against hand-computed values.
module tb_wb_queue;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic        LoadValid;
    logic [4:0]  LoadReg;
    logic [31:0] LoadData;
    logic        AluValid;
    logic [4:0]  AluReg;
    logic [31:0] AluData;
    logic        Stall;
    logic        Overflow;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [4:0]  QueryReg1;
    logic [4:0]  QueryReg2;
    logic        Hit1;
    logic        Hit2;
    logic [31:0] HitData1;
    logic [31:0] HitData2;

    int checks = 0;
    int errors = 0;

    wb_queue #(.DEPTH(4), .WIDTH(32)) dut (
        .Clk(Clk),
        .ResetN(ResetN),
        .LoadValid(LoadValid),
        .LoadReg(LoadReg),
        .LoadData(LoadData),
        .AluValid(AluValid),
        .AluReg(AluReg),
        .AluData(AluData),
        .Stall(Stall),
        .Overflow(Overflow),
        .WriteRegister(WriteRegister),
        .WriteData(WriteData),
        .RegWrite(RegWrite),
        .QueryReg1(QueryReg1),
        .QueryReg2(QueryReg2),
        .Hit1(Hit1),
        .Hit2(Hit2),
        .HitData1(HitData1),
        .HitData2(HitData2)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        LoadValid = 1'b0;
        LoadReg   = 5'd0;
        LoadData  = 32'd0;
        AluValid  = 1'b0;
        AluReg    = 5'd0;
        AluData   = 32'd0;
    endtask

    task automatic dual(input logic [4:0] lr, input logic [31:0] ld,
                        input logic [4:0] ar, input logic [31:0] ad);
        LoadValid = 1'b1;
        LoadReg   = lr;
        LoadData  = ld;
        AluValid  = 1'b1;
        AluReg    = ar;
        AluData   = ad;
    endtask

    task automatic test_reset();
        ResetN    = 1'b0;
        QueryReg1 = 5'd5;
        QueryReg2 = 5'd0;
        idle();
        step();
        step();
        ResetN = 1'b1;
        checks++;
        if ({RegWrite, WriteRegister, WriteData} !== 38'd0) begin
            errors++;
            $display("FAIL reset_write: got %b/%0d/%h want 0/0/0",
                     RegWrite, WriteRegister, WriteData);
        end
        checks++;
        if ({Stall, Overflow, Hit1, Hit2} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {Stall, Overflow, Hit1, Hit2});
        end
        checks++;
        if ({HitData1, HitData2} !== 64'd0) begin
            errors++;
            $display("FAIL reset_hitdata: got %h %h want 0 0", HitData1, HitData2);
        end
    endtask

    task automatic test_single();
        AluValid = 1'b1;
        AluReg   = 5'd5;
        AluData  = 32'hDEADBEEF;
        step();
        idle();
        checks++;
        if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL single_write: got %b/%0d/%h want 1/5/deadbeef",
                     RegWrite, WriteRegister, WriteData);
        end
        checks++;
        if ({Hit1, HitData1} !== {1'b1, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL single_fwd: got %b/%h want 1/deadbeef", Hit1, HitData1);
        end
        step();
        checks++;
        if ({RegWrite, Hit1} !== 2'b00) begin
            errors++;
            $display("FAIL single_retired: got %b want 00", {RegWrite, Hit1});
        end
    endtask

    task automatic test_pair();
        QueryReg1 = 5'd3;
        dual(5'd3, 32'h11, 5'd3, 32'h22);
        step();
        idle();
        checks++;
        if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd3, 32'h11}) begin
            errors++;
            $display("FAIL pair_first: got %b/%0d/%h want 1/3/11",
                     RegWrite, WriteRegister, WriteData);
        end
        checks++;
        if ({Hit1, HitData1} !== {1'b1, 32'h22}) begin
            errors++;
            $display("FAIL pair_fwd_both: got %b/%h want 1/22", Hit1, HitData1);
        end
        step();
        checks++;
        if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd3, 32'h22}) begin
            errors++;
            $display("FAIL pair_second: got %b/%0d/%h want 1/3/22",
                     RegWrite, WriteRegister, WriteData);
        end
        checks++;
        if ({Hit1, HitData1} !== {1'b1, 32'h22}) begin
            errors++;
            $display("FAIL pair_fwd_one: got %b/%h want 1/22", Hit1, HitData1);
        end
        step();
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL pair_empty: got RegWrite=%b want 0", RegWrite);
        end
    endtask

    task automatic test_reg0();
        QueryReg1 = 5'd0;
        AluValid  = 1'b1;
        AluReg    = 5'd0;
        AluData   = 32'hFFFFFFFF;
        step();
        idle();
        checks++;
        if ({RegWrite, Hit1, Stall} !== 3'b000) begin
            errors++;
            $display("FAIL reg0_drop: got RegWrite/Hit1/Stall=%b want 000",
                     {RegWrite, Hit1, Stall});
        end
        dual(5'd0, 32'hFFFFFFFF, 5'd7, 32'h77);
        step();
        idle();
        checks++;
        if ({RegWrite, WriteRegister, WriteData, Hit1} !== {1'b1, 5'd7, 32'h77, 1'b0}) begin
            errors++;
            $display("FAIL reg0_mixed: got %b/%0d/%h hit=%b want 1/7/77 hit=0",
                     RegWrite, WriteRegister, WriteData, Hit1);
        end
        step();
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL reg0_slot: got RegWrite=%b want 0", RegWrite);
        end
    endtask

    task automatic test_fill();
        QueryReg1 = 5'd5;
        QueryReg2 = 5'd8;
        dual(5'd1, 32'h101, 5'd2, 32'h102);
        step();
        checks++;
        if ({Stall, WriteRegister, WriteData} !== {1'b0, 5'd1, 32'h101}) begin
            errors++;
            $display("FAIL fill_c2: got stall=%b %0d/%h want 0 1/101",
                     Stall, WriteRegister, WriteData);
        end
        dual(5'd3, 32'h103, 5'd4, 32'h104);
        step();
        checks++;
        if ({Stall, WriteRegister, WriteData} !== {1'b1, 5'd2, 32'h102}) begin
            errors++;
            $display("FAIL fill_c3: got stall=%b %0d/%h want 1 2/102",
                     Stall, WriteRegister, WriteData);
        end
        dual(5'd5, 32'h105, 5'd6, 32'h106);
        step();
        checks++;
        if ({Overflow, Stall, WriteRegister, WriteData} !== {2'b10, 5'd3, 32'h103}) begin
            errors++;
            $display("FAIL fill_drop: got ovf=%b stall=%b %0d/%h want 1 0 3/103",
                     Overflow, Stall, WriteRegister, WriteData);
        end
        checks++;
        if (Hit1 !== 1'b0) begin
            errors++;
            $display("FAIL fill_dropped_fwd: got Hit1=%b want 0", Hit1);
        end
        dual(5'd7, 32'h107, 5'd8, 32'h108);
        step();
        idle();
        checks++;
        if ({Stall, WriteRegister, WriteData} !== {1'b1, 5'd4, 32'h104}) begin
            errors++;
            $display("FAIL fill_refill: got stall=%b %0d/%h want 1 4/104",
                     Stall, WriteRegister, WriteData);
        end
        checks++;
        if ({Hit2, HitData2} !== {1'b1, 32'h108}) begin
            errors++;
            $display("FAIL fill_fwd2: got %b/%h want 1/108", Hit2, HitData2);
        end
        step();
        checks++;
        if ({Stall, WriteRegister, WriteData} !== {1'b0, 5'd7, 32'h107}) begin
            errors++;
            $display("FAIL fill_wrap7: got stall=%b %0d/%h want 0 7/107",
                     Stall, WriteRegister, WriteData);
        end
        step();
        checks++;
        if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd8, 32'h108}) begin
            errors++;
            $display("FAIL fill_wrap8: got %b/%0d/%h want 1/8/108",
                     RegWrite, WriteRegister, WriteData);
        end
        step();
        checks++;
        if ({RegWrite, Overflow, Hit2} !== 3'b010) begin
            errors++;
            $display("FAIL fill_drained: got RegWrite/Ovf/Hit2=%b want 010",
                     {RegWrite, Overflow, Hit2});
        end
    endtask

    task automatic test_reset_mid();
        QueryReg1 = 5'd9;
        QueryReg2 = 5'd10;
        dual(5'd10, 32'hA, 5'd9, 32'h9);
        step();
        idle();
        ResetN   = 1'b0;
        AluValid = 1'b1;
        AluReg   = 5'd11;
        AluData  = 32'hB;
        #1;
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL rst_cycle_write: got RegWrite=%b want 0", RegWrite);
        end
        step();
        ResetN = 1'b1;
        idle();
        checks++;
        if ({RegWrite, Hit1, Hit2, Overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid: got RegWrite/Hit1/Hit2/Ovf=%b want 0000",
                     {RegWrite, Hit1, Hit2, Overflow});
        end
        AluValid = 1'b1;
        AluReg   = 5'd12;
        AluData  = 32'hC;
        step();
        idle();
        checks++;
        if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd12, 32'hC}) begin
            errors++;
            $display("FAIL rst_after: got %b/%0d/%h want 1/12/c",
                     RegWrite, WriteRegister, WriteData);
        end
        step();
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL rst_after_empty: got RegWrite=%b want 0", RegWrite);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            AluValid = 1'b1;
            AluReg   = 5'(i + 1);
            AluData  = 32'h1000 + 32'(i);
            step();
            checks++;
            if ({Stall, RegWrite, WriteRegister, WriteData}
                    !== {1'b0, 1'b1, 5'(i + 1), 32'h1000 + 32'(i)}) begin
                errors++;
                $display("FAIL stream_%0d: got stall=%b %b/%0d/%h want 0 1/%0d/%h",
                         i, Stall, RegWrite, WriteRegister, WriteData,
                         i + 1, 32'h1000 + 32'(i));
            end
        end
        idle();
        step();
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: got RegWrite=%b want 0", RegWrite);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pair();
        test_reg0();
        test_fill();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
